// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states and queue entry layout.
package fetch_pkg;

    localparam int INSTR_BYTES = 2;
    localparam int PC_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_HI,
        FETCH_LO,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [15:0]         instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue holding {pc, instr} entries; flush beats push and pop.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push    = push && (count < FULL);
    assign do_pop     = pop && (count != '0);
    assign head_valid = (count != '0);
    // Head reads as zero when empty so stale storage never reaches the outputs.
    assign head       = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; validity is tracked by count, so clearing the array would only cost area.
    always_ff @(posedge Clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch stage: reads big-endian 16-bit instructions a byte at a time and queues them with their PC.
module instr_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                  DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 16'd10
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    output logic                   MemReq,
    output logic [PC_WIDTH-1:0]    MemAddr,
    input  logic                   MemAck,
    input  logic [7:0]             MemData,
    output logic                   InstrValid,
    output logic [15:0]            Instruction,
    output logic [PC_WIDTH-1:0]    InstrPC,
    input  logic                   InstrReady,
    input  logic                   Redirect,
    input  logic [PC_WIDTH-1:0]    RedirectPC,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_state_e        state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] pend_pc;
    logic [7:0]          hi_byte;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                outstanding;
    logic                push;
    logic                pop;
    fetch_entry_t        push_entry;
    fetch_entry_t        head;

    assign redirect_target = {RedirectPC[PC_WIDTH-1:1], 1'b0};
    assign outstanding     = MemReq && !MemAck;
    assign push            = (state == FETCH_LO) && MemAck && !Redirect;
    assign pop             = InstrValid && InstrReady;
    assign push_entry      = '{pc: fetch_pc, instr: {hi_byte, MemData}};

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        MemReq  = 1'b0;
        MemAddr = fetch_pc;
        unique case (state)
            FETCH_HI: MemReq = (Count < FULL);
            FETCH_LO: begin
                MemReq  = 1'b1;
                MemAddr = fetch_pc + 16'd1;
            end
            DRAIN:    MemReq = 1'b1;
            default:  ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            hi_byte  <= '0;
        end else if (Redirect) begin
            if (outstanding) begin
                // Park the live address in fetch_pc so MemAddr stays put until the stale ack.
                pend_pc  <= redirect_target;
                fetch_pc <= MemAddr;
                state    <= DRAIN;
            end else begin
                fetch_pc <= redirect_target;
                state    <= FETCH_HI;
            end
        end else begin
            unique case (state)
                IDLE: state <= FETCH_HI;
                FETCH_HI: begin
                    if (MemReq && MemAck) begin
                        hi_byte <= MemData;
                        state   <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (MemAck) begin
                        fetch_pc <= fetch_pc + PC_WIDTH'(INSTR_BYTES);
                        state    <= FETCH_HI;
                    end
                end
                DRAIN: begin
                    if (MemAck) begin
                        fetch_pc <= pend_pc;
                        state    <= FETCH_HI;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (Redirect),
        .head       (head),
        .head_valid (InstrValid),
        .count      (Count)
    );

    assign Instruction = head.instr;
    assign InstrPC     = head.pc;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with a byte memory responder of configurable latency.
module tb_instr_prefetch_unit;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck = 1'b0;
    logic [7:0]  MemData = 8'h00;
    logic        InstrValid;
    logic [15:0] Instruction;
    logic [15:0] InstrPC;
    logic        InstrReady = 1'b0;
    logic        Redirect = 1'b0;
    logic [15:0] RedirectPC = 16'h0000;
    logic [2:0]  Count;

    int checks = 0;
    int failures = 0;

    int          lat = 0;
    logic        mem_stall = 1'b0;
    int          wait_cnt = 0;
    logic        prev_wait = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    int          addr_unstable = 0;
    int          cyc = 0;
    logic [15:0] acked [$];
    logic [31:0] popped [$];
    int          pop_cyc [$];

    instr_prefetch_unit #(.DEPTH(4), .RESET_PC(16'd10)) dut (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .MemReq      (MemReq),
        .MemAddr     (MemAddr),
        .MemAck      (MemAck),
        .MemData     (MemData),
        .InstrValid  (InstrValid),
        .Instruction (Instruction),
        .InstrPC     (InstrPC),
        .InstrReady  (InstrReady),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .Count       (Count)
    );

    always #5 Clock = ~Clock;

    // Memory image: 0x91,0x05 at 10/11, elsewhere addr_lo ^ addr_hi ^ 0xA5.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (a == 16'd10) return 8'h91;
        if (a == 16'd11) return 8'h05;
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Responder decides MemAck for the coming edge at each falling edge.
    always @(negedge Clock) begin
        if (!ResetN) begin
            MemAck    = 1'b0;
            wait_cnt  = 0;
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && (!MemReq || MemAddr !== prev_addr)) addr_unstable++;
            if (MemReq && !mem_stall && wait_cnt >= lat) begin
                MemAck    = 1'b1;
                MemData   = mem_byte(MemAddr);
                acked.push_back(MemAddr);
                wait_cnt  = 0;
                prev_wait = 1'b0;
            end else begin
                MemAck    = 1'b0;
                wait_cnt  = MemReq ? wait_cnt + 1 : 0;
                prev_wait = MemReq;
                prev_addr = MemAddr;
            end
        end
    end

    always @(negedge Clock) begin
        cyc++;
        if (ResetN && InstrValid && InstrReady) begin
            popped.push_back({InstrPC, Instruction});
            pop_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_reset();
        ResetN     = 1'b0;
        Redirect   = 1'b0;
        InstrReady = 1'b0;
        mem_stall  = 1'b0;
        lat        = 0;
        repeat (2) @(posedge Clock);
        #1;
        ResetN = 1'b1;
        acked.delete();
        popped.delete();
        pop_cyc.delete();
    endtask

    task automatic wait_pops(input int n, input int limit, input string name);
        int k = 0;
        while (popped.size() < n && k < limit) begin
            tick();
            k++;
        end
        checks++;
        if (popped.size() < n) begin
            failures++;
            $display("FAIL %s_timeout: pops=%0d required=%0d", name, popped.size(), n);
        end
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (MemReq !== 1'b0) begin failures++; $display("FAIL rst_memreq: got %b exp 0", MemReq); end
        checks++; if (MemAddr !== 16'd10) begin failures++; $display("FAIL rst_memaddr: got %h exp 000a", MemAddr); end
        checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", InstrValid); end
        checks++; if (Instruction !== 16'h0000) begin failures++; $display("FAIL rst_instr: got %h exp 0000", Instruction); end
        checks++; if (InstrPC !== 16'h0000) begin failures++; $display("FAIL rst_pc: got %h exp 0000", InstrPC); end
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d exp 0", Count); end
    endtask

    task automatic test_first_fetch();
        apply_reset();
        checks++; if (MemReq !== 1'b0) begin failures++; $display("FAIL idle_memreq: got %b exp 0", MemReq); end
        tick();
        checks++; if (MemReq !== 1'b1 || MemAddr !== 16'd10) begin failures++; $display("FAIL first_req: got req=%b addr=%h exp req=1 addr=000a", MemReq, MemAddr); end
        tick();
        checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL early_valid: got %b exp 0", InstrValid); end
        tick();
        checks++; if (InstrValid !== 1'b1) begin failures++; $display("FAIL first_valid: got %b exp 1", InstrValid); end
        checks++; if (Instruction !== 16'h9105) begin failures++; $display("FAIL first_instr: got %h exp 9105", Instruction); end
        checks++; if (InstrPC !== 16'd10) begin failures++; $display("FAIL first_pc: got %h exp 000a", InstrPC); end
        InstrReady = 1'b1;
        tick();
        InstrReady = 1'b0;
        checks++; if (InstrValid !== 1'b0 || Count !== 3'd0) begin failures++; $display("FAIL pop_empty: got valid=%b count=%0d exp 0/0", InstrValid, Count); end
        tick();
        checks++; if (InstrValid !== 1'b1 || InstrPC !== 16'd12 || Instruction !== 16'hA9A8) begin
            failures++; $display("FAIL second_instr: got v=%b pc=%h ins=%h exp 1/000c/a9a8", InstrValid, InstrPC, Instruction);
        end
    endtask

    task automatic test_full_queue();
        apply_reset();
        repeat (12) tick();
        checks++; if (Count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d exp 4", Count); end
        checks++; if (MemReq !== 1'b0) begin failures++; $display("FAIL full_memreq: got %b exp 0", MemReq); end
        checks++; if (acked.size() != 8) begin failures++; $display("FAIL full_acks: got %0d exp 8", acked.size()); end
        checks++; if (InstrPC !== 16'd10) begin failures++; $display("FAIL full_head: got %h exp 000a", InstrPC); end
        InstrReady = 1'b1;
        tick();
        InstrReady = 1'b0;
        repeat (5) tick();
        checks++; if (acked.size() != 10) begin failures++; $display("FAIL refill_acks: got %0d exp 10", acked.size()); end
        checks++; if (acked.size() == 10 && (acked[8] !== 16'd18 || acked[9] !== 16'd19)) begin
            failures++; $display("FAIL refill_addrs: got %h,%h exp 0012,0013", acked[8], acked[9]);
        end
        checks++; if (Count !== 3'd4 || MemReq !== 1'b0 || InstrPC !== 16'd12) begin
            failures++; $display("FAIL refill_state: got count=%0d req=%b pc=%h exp 4/0/000c", Count, MemReq, InstrPC);
        end
    endtask

    task automatic test_slow_memory();
        apply_reset();
        lat = 3;
        InstrReady = 1'b1;
        addr_unstable = 0;
        wait_pops(3, 100, "slow");
        InstrReady = 1'b0;
        if (popped.size() >= 3) begin
            checks++; if (popped[0] !== {16'd10, 16'h9105}) begin failures++; $display("FAIL slow_0: got %h exp 000a9105", popped[0]); end
            checks++; if (popped[1] !== {16'd12, 16'hA9A8}) begin failures++; $display("FAIL slow_1: got %h exp 000ca9a8", popped[1]); end
            checks++; if (popped[2] !== {16'd14, 16'hABAA}) begin failures++; $display("FAIL slow_2: got %h exp 000eabaa", popped[2]); end
            checks++; if (pop_cyc[1] - pop_cyc[0] != 8 || pop_cyc[2] - pop_cyc[1] != 8) begin
                failures++; $display("FAIL slow_period: got %0d,%0d exp 8,8", pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1]);
            end
        end
        checks++; if (addr_unstable != 0) begin failures++; $display("FAIL addr_stable: got %0d violations exp 0", addr_unstable); end
    endtask

    task automatic test_redirect_drain();
        apply_reset();
        repeat (3) tick();
        mem_stall = 1'b1;
        tick();
        Redirect   = 1'b1;
        RedirectPC = 16'h0040;
        tick();
        Redirect = 1'b0;
        checks++; if (Count !== 3'd0 || InstrValid !== 1'b0) begin failures++; $display("FAIL drain_flush: got count=%0d v=%b exp 0/0", Count, InstrValid); end
        checks++; if (MemReq !== 1'b1 || MemAddr !== 16'd12) begin failures++; $display("FAIL drain_hold: got req=%b addr=%h exp 1/000c", MemReq, MemAddr); end
        mem_stall = 1'b0;
        tick();
        checks++; if (MemReq !== 1'b1 || MemAddr !== 16'h0040 || Count !== 3'd0) begin
            failures++; $display("FAIL drain_restart: got req=%b addr=%h count=%0d exp 1/0040/0", MemReq, MemAddr, Count);
        end
        InstrReady = 1'b1;
        wait_pops(1, 20, "drain");
        InstrReady = 1'b0;
        checks++; if (popped.size() > 0 && popped[0] !== {16'h0040, 16'hE5E4}) begin failures++; $display("FAIL drain_first: got %h exp 0040e5e4", popped[0]); end
        checks++; if (addr_unstable != 0) begin failures++; $display("FAIL drain_stable: got %0d violations exp 0", addr_unstable); end
    endtask

    task automatic test_wrap();
        apply_reset();
        InstrReady = 1'b1;
        repeat (3) tick();
        Redirect   = 1'b1;
        RedirectPC = 16'hFFFE;
        tick();
        Redirect = 1'b0;
        checks++; if (MemReq !== 1'b1 || MemAddr !== 16'hFFFE || InstrValid !== 1'b0 || Count !== 3'd0) begin
            failures++; $display("FAIL wrap_start: got req=%b addr=%h v=%b count=%0d exp 1/fffe/0/0", MemReq, MemAddr, InstrValid, Count);
        end
        acked.delete();
        popped.delete();
        wait_pops(2, 20, "wrap");
        InstrReady = 1'b0;
        checks++; if (acked.size() < 4 || acked[0] !== 16'hFFFE || acked[1] !== 16'hFFFF || acked[2] !== 16'h0000 || acked[3] !== 16'h0001) begin
            failures++; $display("FAIL wrap_addrs: got %0d acks first=%h exp fffe,ffff,0000,0001", acked.size(), acked.size() > 0 ? acked[0] : 16'hxxxx);
        end
        if (popped.size() >= 2) begin
            checks++; if (popped[0] !== {16'hFFFE, 16'hA4A5}) begin failures++; $display("FAIL wrap_0: got %h exp fffea4a5", popped[0]); end
            checks++; if (popped[1] !== {16'h0000, 16'hA5A4}) begin failures++; $display("FAIL wrap_1: got %h exp 0000a5a4", popped[1]); end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        repeat (4) tick();
        checks++; if (MemAddr !== 16'd13 || Count !== 3'd1) begin failures++; $display("FAIL b2b_pre: got addr=%h count=%0d exp 000d/1", MemAddr, Count); end
        Redirect   = 1'b1;
        RedirectPC = 16'h0041;
        InstrReady = 1'b1;
        tick();
        Redirect   = 1'b0;
        InstrReady = 1'b0;
        checks++; if (Count !== 3'd0 || InstrValid !== 1'b0) begin failures++; $display("FAIL b2b_flush: got count=%0d v=%b exp 0/0", Count, InstrValid); end
        checks++; if (MemReq !== 1'b1 || MemAddr !== 16'h0040) begin failures++; $display("FAIL b2b_target: got req=%b addr=%h exp 1/0040", MemReq, MemAddr); end
        tick();
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL b2b_nopush: got %0d exp 0", Count); end
        repeat (2) tick();
        checks++; if (Count !== 3'd1 || MemAddr !== 16'h0043 || InstrPC !== 16'h0040) begin
            failures++; $display("FAIL b2b_refill: got count=%0d addr=%h pc=%h exp 1/0043/0040", Count, MemAddr, InstrPC);
        end
        #1;
        ResetN = 1'b0;
        #1;
        checks++; if (MemReq !== 1'b0 || MemAddr !== 16'd10 || InstrValid !== 1'b0) begin
            failures++; $display("FAIL midrst_mem: got req=%b addr=%h v=%b exp 0/000a/0", MemReq, MemAddr, InstrValid);
        end
        checks++; if (Count !== 3'd0 || Instruction !== 16'h0000 || InstrPC !== 16'h0000) begin
            failures++; $display("FAIL midrst_queue: got count=%0d ins=%h pc=%h exp 0/0000/0000", Count, Instruction, InstrPC);
        end
        tick();
        ResetN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_full_queue();
        test_slow_memory();
        test_redirect_drain();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Fetch stage of the 16-bit CPU. Reads big-endian 16-bit instructions from the byte-wide instruction memory (high byte at PC, low byte at PC+1), assembles them and buffers them with their PC in a small queue. Decode/datapath pops them through a valid/ready handshake. A redirect input (taken BEQ) flushes the queue and restarts fetch at the branch target.

## Interface
- DEPTH, 4: queue entries, power of two, ≥2
- RESET_PC, 16'd10: first fetch address after reset
- Clock  in  1  rising-edge clock
- ResetN  in  1  asynchronous, active-low reset
- MemReq  out  1  byte read request, held until MemAck
- MemAddr  out  16  byte address of the current request
- MemAck  in  1  read complete; MemData valid this cycle
- MemData  in  8  read byte
- InstrValid  out  1  queue head valid
- Instruction  out  16  queue head instruction
- InstrPC  out  16  address of queue head instruction
- InstrReady  in  1  consumer pops head when InstrValid & InstrReady
- Redirect  in  1  one-cycle pulse: flush and fetch from RedirectPC
- RedirectPC  in  16  new fetch address; bit 0 forced to 0
- Count  out  clog2(DEPTH)+1  occupied entries

## Operation
- Registers: FetchPC, HiByte, PendPC, FSM state, queue.
- States: IDLE, FETCH_HI, FETCH_LO, DRAIN.
- IDLE: reset state; next cycle unconditionally → FETCH_HI.
- FETCH_HI: MemReq = (Count < DEPTH), MemAddr = FetchPC. On MemAck: HiByte ← MemData → FETCH_LO.
- FETCH_LO: MemReq = 1, MemAddr = FetchPC+1. On MemAck: push {FetchPC, HiByte, MemData}, FetchPC ← FetchPC+2 → FETCH_HI.
- DRAIN: MemReq and MemAddr held stable. On MemAck: data discarded, FetchPC ← PendPC → FETCH_HI.
- Redirect: queue emptied that cycle. If a request is outstanding (MemReq=1, no MemAck this cycle): PendPC ← RedirectPC → DRAIN. Otherwise (no request, or MemAck this same cycle): FetchPC ← RedirectPC → FETCH_HI, acked byte discarded, no push.
- Redirect in DRAIN: PendPC overwritten (last one wins).
- Arithmetic: all address arithmetic mod 2^16; FetchPC 16'hFFFE → next 16'h0000; LO address of 16'hFFFE is 16'hFFFF.
- Pop and push same cycle: Count unchanged; push into full queue impossible (HI only issued when Count < DEPTH, queue cannot grow during LO).
- Redirect and pop same cycle: redirect wins, Count → 0.
- Memory protocol: MemAddr must not change while MemReq=1 and MemAck=0; requests are never withdrawn.

## Timing
- Reset values: MemReq 0, MemAddr RESET_PC, InstrValid 0, Instruction 0, InstrPC 0, Count 0, FetchPC RESET_PC, state IDLE.
- Reset asserted mid-operation: all state returns to reset values immediately; outstanding memory request abandoned, memory side must tolerate this.
- Zero-wait memory (MemAck same cycle as MemReq): HI ack cycle n, LO ack cycle n+1, InstrValid at n+2. Sustained throughput 1 instruction / 2 cycles.
- First request after reset release: MemReq high in second cycle (IDLE lasts one cycle).
- Redirect at cycle n with no outstanding request: MemReq with MemAddr=RedirectPC at n+1; InstrValid deasserted from n+1.
- Outputs Instruction/InstrPC/InstrValid driven directly from queue head registers; no combinational path from MemData to them.

## Structure
- Package fetch_pkg: state enum (IDLE, FETCH_HI, FETCH_LO, DRAIN), INSTR_BYTES = 2, PC_WIDTH = 16, queue entry type {pc[15:0], instr[15:0]}.
- Sub-module instr_fifo: synchronous DEPTH×32 FIFO with push, pop, flush, count; flush takes priority over push and pop.
- Top holds FSM, FetchPC/HiByte/PendPC and memory interface.

## Test plan
- Reset release, zero-wait memory with bytes 0x91,0x05 at 10/11 → InstrValid 3 cycles after IDLE exit, Instruction 16'h9105, InstrPC 16'd10; next InstrPC 16'd12.
- InstrReady held 0, zero-wait memory → Count saturates at 4, MemReq 0 in FETCH_HI; one pop → exactly one new 2-byte fetch.
- MemAck delayed 3 cycles per byte → MemAddr stable during wait; each instruction takes 8 cycles; order and PCs correct.
- Redirect to 16'h0040 while HI request waiting → DRAIN, stale byte discarded, next MemAddr 16'h0040, queue empty, first popped InstrPC 16'h0040.
- Redirect with RedirectPC 16'hFFFE → fetch addresses FFFE, FFFF, 0000, 0001; InstrPC 16'hFFFE then 16'h0000.
- Redirect, pop and LO MemAck in same cycle → Count 0, no push, next MemAddr = RedirectPC; ResetN pulsed low mid-FETCH_LO → all outputs at reset values immediately.
